// File: rtl/asic_bufen_seq.sv
`default_nettype none
// ============================================================================
//  Module   : asic_bufen_seq
//  Summary  : Staggered enable sequencer for N buffer/driver banks. Banks are
//             switched on lowest-first with a programmable gap between steps,
//             and switched off highest-first, to limit inrush and ground
//             bounce. Completion is reported with a level ack.
//  Options  : ASIC_BUFEN_SEQ_KILL_EN adds a 'kill' input that forces all
//             banks off immediately and holds the block in OFF.
//  Revision : 1.0 - initial release
// ============================================================================
module asic_bufen_seq #(
    parameter int N    = 4,
    parameter int CW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en_req,
    input  logic [CW-1:0] gap,
`ifdef ASIC_BUFEN_SEQ_KILL_EN
    input  logic          kill,
`endif
    output logic [N-1:0]  en,
    output logic          ack,
    output logic          busy
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_DOWN = 2'd3;

    localparam logic [N-1:0] ALL_ON = '1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_gap;

    logic [1:0]    w_state;
    logic [N-1:0]  w_en;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_gap;
    logic [N-1:0]  w_up;
    logic [N-1:0]  w_dn;
    logic          w_kill;

    // PROP only steers target-specific mapping; it has no behavioural effect.
    logic w_unused_prop;
    assign w_unused_prop = ^PROP;

`ifdef ASIC_BUFEN_SEQ_KILL_EN
    assign w_kill = kill;
`else
    assign w_kill = 1'b0;
`endif

    // Thermometer steps: set the lowest cleared bit / clear the highest set bit.
    assign w_up = (en << 1) | N'(1);
    assign w_dn = en >> 1;

    // Next-state decode: ramp entries and reversals step at once and resample
    // gap; in-ramp steps wait for the counter to drain and reuse the sample.
    always_comb begin
        w_state = r_state;
        w_en    = en;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        case (r_state)
            ST_OFF: begin
                if (en_req) begin
                    w_en    = w_up;
                    w_cnt   = gap;
                    w_gap   = gap;
                    w_state = (w_up == ALL_ON) ? ST_ON : ST_UP;
                end
            end
            ST_UP: begin
                if (!en_req) begin
                    w_en    = w_dn;
                    w_cnt   = gap;
                    w_gap   = gap;
                    w_state = (w_dn == '0) ? ST_OFF : ST_DOWN;
                end else if (r_cnt == '0) begin
                    w_en    = w_up;
                    w_cnt   = r_gap;
                    w_state = (w_up == ALL_ON) ? ST_ON : ST_UP;
                end else begin
                    w_cnt   = r_cnt - CW'(1);
                end
            end
            ST_ON: begin
                if (!en_req) begin
                    w_en    = w_dn;
                    w_cnt   = gap;
                    w_gap   = gap;
                    w_state = (w_dn == '0) ? ST_OFF : ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (en_req) begin
                    w_en    = w_up;
                    w_cnt   = gap;
                    w_gap   = gap;
                    w_state = (w_up == ALL_ON) ? ST_ON : ST_UP;
                end else if (r_cnt == '0) begin
                    w_en    = w_dn;
                    w_cnt   = r_gap;
                    w_state = (w_dn == '0) ? ST_OFF : ST_DOWN;
                end else begin
                    w_cnt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state = ST_OFF;
                w_en    = '0;
                w_cnt   = '0;
            end
        endcase
    end

    // State and registered outputs; reset wins over kill, kill wins over sequencing.
    always_ff @(posedge clk) begin
        if (!nreset || w_kill) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_gap   <= '0;
            en      <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            en      <= w_en;
            ack     <= (w_state == ST_ON);
            busy    <= (w_state == ST_UP) || (w_state == ST_DOWN);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asic_bufen_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_asic_bufen_seq
//  Summary  : Scoreboard bench for asic_bufen_seq with an N=4 and an N=1
//             instance sharing stimulus. A bank-count reference model pushes
//             expected outputs each edge; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_asic_bufen_seq;

    logic       clk;
    logic       nreset;
    logic       en_req;
    logic [7:0] gap;
    logic       kill_v;
    logic [3:0] en0;
    logic       ack0;
    logic       busy0;
    logic [0:0] en1;
    logic       ack1;
    logic       busy1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int en0; int ack0; int busy0;
        int en1; int ack1; int busy1;
    } exp_t;
    exp_t sb[$];

    // Reference model: number of banks on, ramp direction, remaining wait.
    int lvl[2];
    int dir[2];
    int wt[2];
    int gs[2];
    int nb[2];

    asic_bufen_seq #(.N(4), .CW(8), .PROP("DEFAULT")) dut4 (
        .clk(clk), .nreset(nreset), .en_req(en_req), .gap(gap),
`ifdef ASIC_BUFEN_SEQ_KILL_EN
        .kill(kill_v),
`endif
        .en(en0), .ack(ack0), .busy(busy0)
    );

    asic_bufen_seq #(.N(1), .CW(8), .PROP("DEFAULT")) dut1 (
        .clk(clk), .nreset(nreset), .en_req(en_req), .gap(gap),
`ifdef ASIC_BUFEN_SEQ_KILL_EN
        .kill(kill_v),
`endif
        .en(en1), .ack(ack1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input int i, input bit rn, input bit req,
                              input int g, input bit kl);
        int want;
        if (!rn || kl) begin
            lvl[i] = 0; dir[i] = 0; wt[i] = 0;
        end else if (dir[i] == 0) begin
            if (req && lvl[i] == 0) begin
                gs[i] = g; wt[i] = g; lvl[i] = 1;
                dir[i] = (lvl[i] == nb[i]) ? 0 : 1;
            end else if (!req && lvl[i] == nb[i]) begin
                gs[i] = g; wt[i] = g; lvl[i] = nb[i] - 1;
                dir[i] = (lvl[i] == 0) ? 0 : -1;
            end
        end else begin
            want = req ? 1 : -1;
            if (want != dir[i]) begin
                gs[i] = g; wt[i] = g; dir[i] = want; lvl[i] += want;
            end else if (wt[i] == 0) begin
                wt[i] = gs[i]; lvl[i] += dir[i];
            end else begin
                wt[i] -= 1;
            end
            if (lvl[i] == 0 || lvl[i] == nb[i]) dir[i] = 0;
        end
    endtask

    // One clock edge: advance the model on the sampled inputs, queue the
    // expected outputs, then return just after the edge for new stimulus.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, nreset, en_req, int'(gap), kill_v);
        e.en0   = (1 << lvl[0]) - 1;
        e.ack0  = (dir[0] == 0 && lvl[0] == nb[0]) ? 1 : 0;
        e.busy0 = (dir[0] != 0) ? 1 : 0;
        e.en1   = (1 << lvl[1]) - 1;
        e.ack1  = (dir[1] == 0 && lvl[1] == nb[1]) ? 1 : 0;
        e.busy1 = (dir[1] != 0) ? 1 : 0;
        sb.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("en_n4",   int'(en0),   e.en0);
                check("ack_n4",  int'(ack0),  e.ack0);
                check("busy_n4", int'(busy0), e.busy0);
                check("en_n1",   int'(en1),   e.en1);
                check("ack_n1",  int'(ack1),  e.ack1);
                check("busy_n1", int'(busy1), e.busy1);
            end
        end
    end

    initial begin
        nb[0] = 4; nb[1] = 1;
        for (int i = 0; i < 2; i++) begin
            lvl[i] = 0; dir[i] = 0; wt[i] = 0; gs[i] = 0;
        end
        kill_v = 1'b0;
        // Reset held with a pending request.
        nreset = 1'b0; en_req = 1'b1; gap = 8'd5;
        repeat (3) tick();
        // Ramp up then down with gap=2.
        nreset = 1'b1; gap = 8'd2;
        repeat (14) tick();
        en_req = 1'b0;
        repeat (14) tick();
        // gap=0: one step per edge.
        gap = 8'd0; en_req = 1'b1;
        repeat (6) tick();
        en_req = 1'b0;
        repeat (6) tick();
        // Reversals with gap=3, then a gap change mid-ramp.
        gap = 8'd3; en_req = 1'b1;
        repeat (5) tick();
        en_req = 1'b0;
        repeat (2) tick();
        en_req = 1'b1;
        repeat (3) tick();
        gap = 8'd1;
        repeat (12) tick();
        // Reset mid-ramp.
        en_req = 1'b0; gap = 8'd2;
        repeat (20) tick();
        en_req = 1'b1;
        repeat (4) tick();
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
`ifdef ASIC_BUFEN_SEQ_KILL_EN
        repeat (16) tick();
        kill_v = 1'b1;
        repeat (3) tick();
        kill_v = 1'b0;
`endif
        repeat (6) tick();
        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 11) == 0) en_req = ~en_req;
            if ($urandom_range(0, 7) == 0) gap = 8'($urandom_range(0, 3));
            nreset = ($urandom_range(0, 119) == 0) ? 1'b0 : 1'b1;
`ifdef ASIC_BUFEN_SEQ_KILL_EN
            if ($urandom_range(0, 59) == 0) kill_v = ~kill_v;
`endif
            tick();
        end
        // Drain the scoreboard within a bounded number of cycles.
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
